// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: width codes, FSM states and
// the store byte-merge helpers.
package cache_pkg;

  localparam logic [1:0] WidthWord = 2'd0;
  localparam logic [1:0] WidthHalf = 2'd1;
  localparam logic [1:0] WidthByte = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWriteback,
    StAllocate,
    StWriteAround
  } state_e;

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [1:0] width);
    logic [31:0] a;
    a = addr;
    case (width)
      WidthByte: a = addr;
      WidthHalf: a[0] = 1'b0;
      default:   a[1:0] = 2'b00;
    endcase
    return a;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] width, input logic [1:0] a);
    logic [3:0] m;
    case (width)
      WidthByte: m = 4'b0001 << a;
      WidthHalf: m = a[1] ? 4'b1100 : 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

  // Right-aligned store data, upper bits cleared according to width.
  function automatic logic [31:0] width_data(input logic [31:0] wdata, input logic [1:0] width);
    logic [31:0] d;
    case (width)
      WidthByte: d = {24'h0, wdata[7:0]};
      WidthHalf: d = {16'h0, wdata[15:0]};
      default:   d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wdata,
                                             input logic [1:0] width, input logic [1:0] a);
    logic [3:0]  m;
    logic [31:0] d;
    logic [31:0] r;
    m = byte_mask(width, a);
    case (width)
      WidthByte: d = {4{wdata[7:0]}};
      WidthHalf: d = {2{wdata[15:0]}};
      default:   d = wdata;
    endcase
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = m[i] ? d[8*i +: 8] : old[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU: walks the tree bits to a victim way, and computes the bits that
// point away from an accessed way.
module plru_tree #(
  parameter int unsigned WAY_BITS = 1,
  localparam int unsigned WAYS = 1 << WAY_BITS,
  localparam int unsigned TREE_W = (WAYS > 1) ? WAYS - 1 : 1,
  localparam int unsigned WIDX = (WAY_BITS > 0) ? WAY_BITS : 1
) (
  input  logic [TREE_W-1:0] tree,
  input  logic [WIDX-1:0]   access_way,
  output logic [WIDX-1:0]   victim,
  output logic [TREE_W-1:0] tree_next
);

  // Heap-ordered nodes: node n has bit n-1, children 2n and 2n+1; bit 0 picks left.
  always_comb begin : victim_walk
    int   node;
    logic b;
    node = 1;
    b = 1'b0;
    for (int l = 0; l < int'(WAY_BITS); l++) begin
      b = 1'b0;
      for (int n = 0; n < int'(TREE_W); n++) begin
        if (n == node - 1) b = tree[n];
      end
      node = 2 * node + (b ? 1 : 0);
    end
    victim = WIDX'(node - int'(WAYS));
  end

  always_comb begin : access_update
    int              node;
    logic [WIDX-1:0] aw;
    logic            b;
    node = 1;
    aw = access_way;
    b = 1'b0;
    tree_next = tree;
    for (int l = 0; l < int'(WAY_BITS); l++) begin
      b = aw[WIDX-1];
      aw = aw << 1;
      for (int n = 0; n < int'(TREE_W); n++) begin
        if (n == node - 1) tree_next[n] = ~b;
      end
      node = 2 * node + (b ? 1 : 0);
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back cache with tree PLRU and valid/ready handshakes.
// Define CACHE_WRITE_ALLOCATE_EN to allocate on store miss; otherwise store misses write around.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned SET_BITS = 2,
  parameter int unsigned WAY_BITS = 1,
  parameter int unsigned OFFSET_BITS = 4,
  localparam int unsigned BLOCK_BITS = 8 << OFFSET_BITS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_write,
  input  logic [1:0]            cpu_req_width,
  input  logic [31:0]           cpu_req_addr,
  input  logic [31:0]           cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [31:0]           cpu_resp_rdata,
  output logic                  mem_req_valid,
  output logic                  mem_req_write,
  output logic [1:0]            mem_req_width,
  output logic [31:0]           mem_req_addr,
  output logic [BLOCK_BITS-1:0] mem_req_wdata,
  input  logic                  mem_resp_ready,
  input  logic [BLOCK_BITS-1:0] mem_resp_data
);

  localparam int unsigned TAG_BITS = 32 - SET_BITS - OFFSET_BITS;
  localparam int unsigned WAYS = 1 << WAY_BITS;
  localparam int unsigned SETS = 1 << SET_BITS;
  localparam int unsigned WIDX = (WAY_BITS > 0) ? WAY_BITS : 1;
  localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

`ifdef CACHE_WRITE_ALLOCATE_EN
  localparam bit WriteAlloc = 1'b1;
`else
  localparam bit WriteAlloc = 1'b0;
`endif

  state_e state_q, state_d;

  logic        req_write_q;
  logic [1:0]  req_width_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [WIDX-1:0] victim_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;

  logic [TAG_BITS-1:0]   tag_q   [SETS][WAYS];
  logic [BLOCK_BITS-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [PLRU_W-1:0]     plru_q  [SETS];

  logic [SET_BITS-1:0]    req_set;
  logic [TAG_BITS-1:0]    req_tag;
  logic [OFFSET_BITS-1:0] word_byte;
  logic                   hit;
  logic [WIDX-1:0]        hit_way;
  logic                   has_inv;
  logic [WIDX-1:0]        inv_way;
  logic [WIDX-1:0]        plru_victim;
  logic [WIDX-1:0]        victim;
  logic [WIDX-1:0]        acc_way;
  logic [PLRU_W-1:0]      plru_next;

  logic [BLOCK_BITS-1:0] hit_block, hit_block_m, fill_block_m;
  logic [31:0]           hit_word, hit_word_m, fill_word, fill_word_m;

  assign req_set   = req_addr_q[OFFSET_BITS +: SET_BITS];
  assign req_tag   = req_addr_q[31 -: TAG_BITS];
  assign word_byte = req_addr_q[OFFSET_BITS-1:0] & ~OFFSET_BITS'(3);

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
        hit = 1'b1;
        hit_way = WIDX'(w);
      end
    end
  end

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[req_set][w]) begin
        has_inv = 1'b1;
        inv_way = WIDX'(w);
      end
    end
  end

  assign victim  = has_inv ? inv_way : plru_victim;
  assign acc_way = (state_q == StLookup) ? hit_way : victim_q;

  plru_tree #(
    .WAY_BITS(WAY_BITS)
  ) u_plru (
    .tree      (plru_q[req_set]),
    .access_way(acc_way),
    .victim    (plru_victim),
    .tree_next (plru_next)
  );

  always_comb begin
    hit_block = data_q[req_set][hit_way];
    hit_word = hit_block[{word_byte, 3'b000} +: 32];
    hit_word_m = merge_word(hit_word, req_wdata_q, req_width_q, req_addr_q[1:0]);
    hit_block_m = hit_block;
    hit_block_m[{word_byte, 3'b000} +: 32] = hit_word_m;
    fill_word = mem_resp_data[{word_byte, 3'b000} +: 32];
    fill_word_m = req_write_q ? merge_word(fill_word, req_wdata_q, req_width_q, req_addr_q[1:0])
                              : fill_word;
    fill_block_m = mem_resp_data;
    fill_block_m[{word_byte, 3'b000} +: 32] = fill_word_m;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (cpu_req_valid) state_d = StLookup;
      StLookup: begin
        if (hit) begin
          state_d = StIdle;
        end else if (req_write_q && !WriteAlloc) begin
          state_d = StWriteAround;
        end else if (valid_q[req_set][victim] && dirty_q[req_set][victim]) begin
          state_d = StWriteback;
        end else begin
          state_d = StAllocate;
        end
      end
      StWriteback:   if (mem_resp_ready) state_d = StAllocate;
      StAllocate:    if (mem_resp_ready) state_d = StIdle;
      StWriteAround: if (mem_resp_ready) state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_width = WidthWord;
    mem_req_addr  = req_addr_q;
    mem_req_wdata = '0;
    case (state_q)
      StWriteback: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_q[req_set][victim_q], req_set, {OFFSET_BITS{1'b0}}};
        mem_req_wdata = data_q[req_set][victim_q];
      end
      StAllocate: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      end
      StWriteAround: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_width = req_width_q;
        mem_req_wdata = BLOCK_BITS'(width_data(req_wdata_q, req_width_q))
                        << {req_addr_q[OFFSET_BITS-1:0], 3'b000};
      end
      default: ;
    endcase
  end

  assign cpu_req_ready  = (state_q == StIdle);
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_resp_rdata = rdata_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      req_write_q  <= 1'b0;
      req_width_q  <= WidthWord;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      victim_q     <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      if (state_q == StIdle && cpu_req_valid) begin
        req_write_q <= cpu_req_write;
        req_width_q <= cpu_req_width;
        req_addr_q  <= align_addr(cpu_req_addr, cpu_req_width);
        req_wdata_q <= cpu_req_wdata;
      end
      if (state_q == StLookup) begin
        victim_q <= victim;
        if (hit) begin
          resp_valid_q <= 1'b1;
          rdata_q      <= req_write_q ? hit_word_m : hit_word;
        end
      end
      if (state_q == StAllocate && mem_resp_ready) begin
        resp_valid_q <= 1'b1;
        rdata_q      <= fill_word_m;
      end
      if (state_q == StWriteAround && mem_resp_ready) resp_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (state_q == StLookup && hit) begin
        plru_q[req_set] <= plru_next;
        if (req_write_q) dirty_q[req_set][hit_way] <= 1'b1;
      end
      if (state_q == StWriteback && mem_resp_ready) dirty_q[req_set][victim_q] <= 1'b0;
      if (state_q == StAllocate && mem_resp_ready) begin
        valid_q[req_set][victim_q] <= 1'b1;
        dirty_q[req_set][victim_q] <= req_write_q;
        plru_q[req_set]            <= plru_next;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == StLookup && hit && req_write_q) begin
        data_q[req_set][hit_way] <= hit_block_m;
      end
      if (state_q == StAllocate && mem_resp_ready) begin
        tag_q[req_set][victim_q]  <= req_tag;
        data_q[req_set][victim_q] <= fill_block_m;
      end
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed table-driven bench for assoc_cache with a 16-cycle block memory model.
module tb_assoc_cache;

  localparam int BLOCK_BITS = 128;
  localparam int LAT = 16;

`ifdef CACHE_WRITE_ALLOCATE_EN
  localparam bit WaBuild = 1'b0;
`else
  localparam bit WaBuild = 1'b1;
`endif

  logic                  CLK;
  logic                  RST;
  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic                  cpu_req_write;
  logic [1:0]            cpu_req_width;
  logic [31:0]           cpu_req_addr;
  logic [31:0]           cpu_req_wdata;
  logic                  cpu_resp_valid;
  logic [31:0]           cpu_resp_rdata;
  logic                  mem_req_valid;
  logic                  mem_req_write;
  logic [1:0]            mem_req_width;
  logic [31:0]           mem_req_addr;
  logic [BLOCK_BITS-1:0] mem_req_wdata;
  logic                  mem_resp_ready;
  logic [BLOCK_BITS-1:0] mem_resp_data;

  assoc_cache #(
    .SET_BITS(2),
    .WAY_BITS(1),
    .OFFSET_BITS(4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_write (cpu_req_write),
    .cpu_req_width (cpu_req_width),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_write (mem_req_write),
    .mem_req_width (mem_req_width),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_resp_ready(mem_resp_ready),
    .mem_resp_data (mem_resp_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: byte i initialised to i[7:0] ^ {i[11:8], i[11:8]}.
  logic [7:0]  mem [4096];
  bit          init_done;
  bit          cur_store;
  int          mcnt;
  int          log_n;
  logic        log_w [64];
  logic [31:0] log_a [64];

  function automatic logic [BLOCK_BITS-1:0] read_block(input int base);
    logic [BLOCK_BITS-1:0] b;
    for (int i = 0; i < 16; i++) b[8*i +: 8] = mem[base + i];
    return b;
  endfunction

  always @(posedge CLK) begin : mem_model
    mem_resp_ready <= 1'b0;
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ {2{4'(i >> 8)}};
      init_done <= 1'b1;
    end
    if (RST) begin
      mcnt <= 0;
    end else if (mem_req_valid && !mem_resp_ready) begin
      if (mcnt == LAT - 1) begin
        mcnt <= 0;
        mem_resp_ready <= 1'b1;
        if (log_n < 64) begin
          log_w[log_n] <= mem_req_write;
          log_a[log_n] <= mem_req_addr;
          log_n <= log_n + 1;
        end
        if (mem_req_write && cur_store && WaBuild) begin
          for (int b = 0; b < ((mem_req_width == 2'd2) ? 1 : (mem_req_width == 2'd1) ? 2 : 4); b++)
            mem[int'(mem_req_addr[11:0]) + b] <=
                mem_req_wdata[(int'(mem_req_addr[3:0]) + b) * 8 +: 8];
        end else if (mem_req_write) begin
          for (int b = 0; b < 16; b++)
            mem[int'({mem_req_addr[11:4], 4'h0}) + b] <= mem_req_wdata[8*b +: 8];
        end else begin
          mem_resp_data <= read_block(int'({mem_req_addr[11:4], 4'h0}));
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  int n_pass;
  int n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_req(input logic wr, input logic [1:0] wd, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
    int n;
    @(negedge CLK);
    cur_store = wr;
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_width = wd;
    cpu_req_addr = a;
    cpu_req_wdata = d;
    @(posedge CLK);
    #1;
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'($urandom);
    cpu_req_width = 2'($urandom);
    cpu_req_addr = $urandom;
    cpu_req_wdata = $urandom;
    n = 1;
    while (!cpu_resp_valid && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
    lat = cpu_resp_valid ? n : -1;
    rd = cpu_resp_rdata;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_nmem;
    logic        exp_w0;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  initial begin : stim
    logic [31:0] rd;
    int          lat;
    int          start;
    int          stray;

    n_pass = 0;
    n_total = 0;
    log_n = 0;
    cur_store = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'b0;
    cpu_req_width = 2'd0;
    cpu_req_addr = '0;
    cpu_req_wdata = '0;

    vecs[0]  = '{1'b0, 2'd0, 32'h010, 32'h0, 1'b1, 32'h13121110, 19, 1, 1'b0, 32'h010, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 32'h010, 32'h0, 1'b1, 32'h13121110, 2, 0, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{1'b1, 2'd2, 32'h013, 32'hFFFFFFAB, 1'b0, 32'h0, 2, 0, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 2'd0, 32'h010, 32'h0, 1'b1, 32'hAB121110, 2, 0, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 2'd1, 32'h016, 32'h0, 1'b1, 32'h17161514, 2, 0, 1'b0, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 2'd1, 32'h016, 32'hFFFFBEEF, 1'b0, 32'h0, 2, 0, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 2'd0, 32'h014, 32'h0, 1'b1, 32'hBEEF1514, 2, 0, 1'b0, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 2'd0, 32'h000, 32'h0, 1'b1, 32'h03020100, 19, 1, 1'b0, 32'h000, 32'h0};
    vecs[8]  = '{1'b0, 2'd0, 32'h040, 32'h0, 1'b1, 32'h43424140, 19, 1, 1'b0, 32'h040, 32'h0};
    vecs[9]  = '{1'b0, 2'd0, 32'h000, 32'h0, 1'b1, 32'h03020100, 2, 0, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 2'd0, 32'h080, 32'h0, 1'b1, 32'h83828180, 19, 1, 1'b0, 32'h080, 32'h0};
    vecs[11] = '{1'b0, 2'd0, 32'h000, 32'h0, 1'b1, 32'h03020100, 2, 0, 1'b0, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 2'd0, 32'h040, 32'h0, 1'b1, 32'h43424140, 19, 1, 1'b0, 32'h040, 32'h0};
    vecs[13] = '{1'b1, 2'd0, 32'h004, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1'b0, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 2'd0, 32'h040, 32'h0, 1'b1, 32'h43424140, 2, 0, 1'b0, 32'h0, 32'h0};
    vecs[15] = '{1'b0, 2'd0, 32'h080, 32'h0, 1'b1, 32'h83828180, 36, 2, 1'b1, 32'h000, 32'h080};
    vecs[16] = '{1'b0, 2'd0, 32'h004, 32'h0, 1'b1, 32'hDEADBEEF, 19, 1, 1'b0, 32'h000, 32'h0};
`ifdef CACHE_WRITE_ALLOCATE_EN
    vecs[17] = '{1'b1, 2'd0, 32'h200, 32'h12345678, 1'b0, 32'h0, 19, 1, 1'b0, 32'h200, 32'h0};
    vecs[18] = '{1'b0, 2'd0, 32'h200, 32'h0, 1'b1, 32'h12345678, 2, 0, 1'b0, 32'h0, 32'h0};
`else
    vecs[17] = '{1'b1, 2'd0, 32'h200, 32'h12345678, 1'b0, 32'h0, 19, 1, 1'b1, 32'h200, 32'h0};
    vecs[18] = '{1'b0, 2'd0, 32'h200, 32'h0, 1'b1, 32'h12345678, 19, 1, 1'b0, 32'h200, 32'h0};
`endif

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("reset ready", 32'(cpu_req_ready), 32'd1);
    check("reset resp_valid", 32'(cpu_resp_valid), 32'd0);
    check("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("reset rdata", cpu_resp_rdata, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      start = log_n;
      do_req(vecs[i].wr, vecs[i].width, vecs[i].addr, vecs[i].wdata, rd, lat);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].chk) check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d mem_reqs", i), 32'(log_n - start), 32'(vecs[i].exp_nmem));
      if (vecs[i].exp_nmem > 0) begin
        check($sformatf("v%0d mem0 write", i), 32'(log_w[start]), 32'(vecs[i].exp_w0));
        check($sformatf("v%0d mem0 addr", i), log_a[start], vecs[i].exp_a0);
      end
      if (vecs[i].exp_nmem > 1) begin
        check($sformatf("v%0d mem1 write", i), 32'(log_w[start + 1]), 32'd0);
        check($sformatf("v%0d mem1 addr", i), log_a[start + 1], vecs[i].exp_a1);
      end
    end

    // Reset in the middle of an ALLOCATE aborts it and invalidates every line.
    @(negedge CLK);
    cur_store = 1'b0;
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b0;
    cpu_req_width = 2'd0;
    cpu_req_addr = 32'h300;
    @(posedge CLK);
    #1;
    cpu_req_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("alloc ready low", 32'(cpu_req_ready), 32'd0);
    check("alloc mem_req_valid", 32'(mem_req_valid), 32'd1);
    check("alloc mem_req_write", 32'(mem_req_write), 32'd0);
    check("alloc mem_req_addr", mem_req_addr, 32'h300);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst ready", 32'(cpu_req_ready), 32'd1);
    check("rst resp_valid", 32'(cpu_resp_valid), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    stray = 0;
    repeat (24) begin
      @(posedge CLK);
      #1;
      if (cpu_resp_valid || mem_req_valid) stray++;
    end
    check("no activity after abort", 32'(stray), 32'd0);
    start = log_n;
    do_req(1'b0, 2'd0, 32'h010, 32'h0, rd, lat);
    check("reload latency", 32'(lat), 32'd19);
    check("reload rdata", rd, 32'h13121110);
    check("reload mem_reqs", 32'(log_n - start), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
